// File: rtl/pdm_decimator.sv
// pdm_decimator: 1-bit PDM stream to unsigned PCM via a 3rd-order CIC
// decimator (ratio 2^LOG2_R), with warm-up suppression of the first strobes.
module pdm_decimator #(
  parameter int unsigned LOG2_R = 6,
  parameter int unsigned OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pdm_en,
  input  logic             pdm_in,
  output logic [OUT_W-1:0] pcm_out,
  output logic             pcm_valid
);

  localparam int unsigned GAIN_W = 3 * LOG2_R;
  localparam int unsigned W      = GAIN_W + 1;
  localparam int unsigned SHIFT  = GAIN_W - OUT_W;
  localparam logic [LOG2_R-1:0] CNT_LAST = '1;
  localparam logic [1:0]        WU_DONE  = 2'd3;

  logic [W-1:0]      i1, i2, i3;
  logic [W-1:0]      d1, d2, d3;
  logic [LOG2_R-1:0] dec_cnt;
  logic              dec_tick;
  logic [1:0]        wu;

  logic [W-1:0]      c1_c, c2_c, c3_c;
  logic [GAIN_W-1:0] sat_c;
  logic [OUT_W-1:0]  pcm_next_c;

  // Integrator chain, advanced only on enabled bit edges (modulo 2^W).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else if (pdm_en) begin
      i1 <= i1 + {{(W-1){1'b0}}, pdm_in};
      i2 <= i2 + i1;
      i3 <= i3 + i2;
    end
  end

  // Decimation counter and the one-cycle tick after each R-th enabled bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt  <= '0;
      dec_tick <= 1'b0;
    end else begin
      dec_tick <= pdm_en && (dec_cnt == CNT_LAST);
      if (pdm_en) begin
        dec_cnt <= dec_cnt + LOG2_R'(1);
      end
    end
  end

  // Comb differences and saturation of the full-scale R^3 case to R^3-1.
  always_comb begin
    c1_c       = i3 - d1;
    c2_c       = c1_c - d2;
    c3_c       = c2_c - d3;
    sat_c      = c3_c[W-1] ? {GAIN_W{1'b1}} : c3_c[GAIN_W-1:0];
    pcm_next_c = OUT_W'(sat_c >> SHIFT);
  end

  // Comb delay registers, updated once per decimated sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (dec_tick) begin
      d1 <= i3;
      d2 <= c1_c;
      d3 <= c2_c;
    end
  end

  // Output sample register, warm-up counter and strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      wu        <= '0;
    end else begin
      pcm_valid <= dec_tick && (wu == WU_DONE);
      if (dec_tick) begin
        pcm_out <= pcm_next_c;
        if (wu != WU_DONE) begin
          wu <= wu + 2'd1;
        end
      end
    end
  end

endmodule

// File: doc/pdm_decimator.md
# pdm_decimator

Receive-side counterpart of the PDM audio modulator. It takes a 1-bit pulse-density-modulated stream and recovers unsigned PCM samples with a 3rd-order CIC decimation filter. It sits between a PDM source (external PDM mic, or the modulator's output looped back for self-test) and any sample consumer. It emits one `pcm_valid` strobe per decimated sample.

## Interface
- `LOG2_R`, default 6: log2 of the decimation ratio R; R = 2^LOG2_R = 64. Legal range 2..8.
- `OUT_W`, default 16: PCM output width. Constraint: OUT_W <= 3*LOG2_R.
- `clk` input, 1 bit: single clock; all state on rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low. Clears all state immediately.
- `pdm_en` input, 1 bit: bit-strobe. `pdm_in` is consumed only on edges where it is 1. Tie high for one bit per clk.
- `pdm_in` input, 1 bit: PDM data, synchronous to `clk`. 1 counts as +1, 0 counts as 0.
- `pcm_out` output, OUT_W bits: unsigned PCM sample. Held between strobes.
- `pcm_valid` output, 1 bit: one-clk pulse when `pcm_out` carries a new sample.

## Operation
- Internal width W = 3*LOG2_R + 1 (19 by default). All integrator and comb arithmetic is modulo 2^W. Wrap-around is intentional and must not saturate.
- Integrators update only on `pdm_en` edges, as a registered chain using pre-edge values: i1 <= i1 + pdm_in, i2 <= i2 + i1, i3 <= i3 + i2.
- Decimation counter (LOG2_R bits) increments on each `pdm_en` edge and wraps R-1 -> 0.
- An enabled edge with counter == R-1 sets register `dec_tick`, which is high for exactly one following cycle.
- Comb stage runs only in the `dec_tick` cycle:
  - c1 = i3 - d1, c2 = c1 - d2, c3 = c2 - d3 (combinational).
  - On the edge: d1 <= i3, d2 <= c1, d3 <= c2.
- Output scaling:
  - s = min(c3, R^3 - 1), treating c3 as unsigned W bits.
  - `pcm_out` <= s >> (3*LOG2_R - OUT_W).
  - DC gain: full density maps to 2^OUT_W - 1; density p maps to floor(p*R^3) >> shift.
- Warm-up: 2-bit counter `wu` saturates at 3 and increments on each `dec_tick`.
  - `pcm_out` updates on every tick.
  - `pcm_valid` asserts only on ticks where `wu` == 3 before the edge, so the first 3 ticks after reset are suppressed.
- `pdm_en` low: integrators, decimation counter, combs and `wu` all hold. `dec_tick` still fires if it was already set.
- Reset values: all integrators, combs, counter, `wu` and `dec_tick` = 0; `pcm_out` = 0; `pcm_valid` = 0.
- Reset mid-operation: async clear of everything, including a pending `dec_tick`. The warm-up restarts from zero.
- No backpressure. The consumer must take the sample in the `pcm_valid` cycle.

## Timing
- Enabled edge E samples the R-th bit of a frame, then:
  - `dec_tick` is high in cycle E..E+1;
  - `pcm_out` updates at edge E+1;
  - `pcm_valid` is high for the single cycle E+1..E+2.
- Latency from the R-th bit to the strobe: 2 clk.
- The integrator chain adds a 2-enabled-sample group delay to the data. The filter impulse response spans 3R-2 enabled samples.
- With `pdm_en` tied high, edges are counted from the first edge after `rst_n` rises (edge 1):
  - the first strobe follows edge 4R+1 (257 by default);
  - subsequent strobes come every R clks.
- With `pdm_en` duty 1/k, strobes come every k*R clks, with values identical to the continuous case.
- `pcm_valid` never asserts on two consecutive cycles.

## Test plan
- `pdm_en`=1, `pdm_in`=0 constant from reset -> first `pcm_valid` after edge 257, `pcm_out`=0x0000 on every strobe.
- `pdm_en`=1, `pdm_in`=1 constant -> first valid `pcm_out`=0xFFFF (R^3 saturated, then >>2); no strobes on ticks 1-3; strobe period 64 clks.
- Alternating 1,0,1,0… -> every valid `pcm_out`=0x8000. Repeating 1,0,0,0 -> 0x4000.
- `pdm_en` asserted every 4th clk, `pdm_in`=1 -> `pcm_out`=0xFFFF, strobes 256 clks apart, first strobe 2 clk after the 256th enabled edge.
- All-ones input, `rst_n` pulsed low mid-frame at clk ~500 -> `pcm_out`=0 and `pcm_valid`=0 immediately (async); the next strobe occurs 4R+1 edges after release with 0xFFFF.
- Loopback: existing PDM modulator driven with a constant 16-bit sample 0x4000 (full scale 0x10000), output fed to `pdm_in` -> settled `pcm_out` within ±1 LSB of 0x4000; 1-bit modulator quantisation is the only error.
